// File: rtl/braille_key_debounce_pkg.sv
// Shared definitions for the Braille key debouncer: channel state encodings
// and default parameter values.
package braille_key_debounce_pkg;

    // Per-channel debounce states
    typedef enum logic [1:0] {
        CH_REL       = 2'd0,
        CH_PRESS_CHK = 2'd1,
        CH_PRS       = 2'd2,
        CH_REL_CHK   = 2'd3
    } ch_state_e;

    localparam int DEFAULT_NUM_KEYS  = 6;
    localparam int DEFAULT_STABLE_MS = 20;
    localparam int DEFAULT_CNT_W     = 5;

    // True when a tick arrives and the stability counter sits on its last value
    function automatic logic accept_now(input logic tick, input logic last_cnt);
        return tick & last_cnt;
    endfunction

endpackage

// File: rtl/braille_key_debounce_ch.sv
// One debounce channel: 2-FF synchronizer, four-state debounce FSM and a
// stability counter advanced only by the 1 ms strobe.
module braille_key_debounce_ch
    import braille_key_debounce_pkg::*;
#(
    parameter int STABLE_MS = DEFAULT_STABLE_MS,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1ms,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_MS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept_s;

    assign s        = sync_q[1];
    assign accept_s = accept_now(tick_1ms, (cnt_q == LAST_CNT));

    // Bring the asynchronous switch input into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // Debounce next-state, counter and output decisions; a bounce always beats a tick
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            CH_REL: begin
                if (s) begin
                    state_d = CH_PRESS_CHK;
                    cnt_d   = '0;
                end else begin
                    state_d = CH_REL;
                end
            end
            CH_PRESS_CHK: begin
                if (!s) begin
                    state_d = CH_REL;
                    cnt_d   = '0;
                end else if (accept_s) begin
                    state_d = CH_PRS;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else if (tick_1ms) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            CH_PRS: begin
                if (!s) begin
                    state_d = CH_REL_CHK;
                    cnt_d   = '0;
                end else begin
                    state_d = CH_PRS;
                end
            end
            CH_REL_CHK: begin
                if (s) begin
                    state_d = CH_PRS;
                    cnt_d   = '0;
                end else if (accept_s) begin
                    state_d   = CH_REL;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else if (tick_1ms) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = CH_REL;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CH_REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/braille_key_debounce.sv
// Braille key debouncer top: reset synchronizer, NUM_KEYS independent debounce
// channels and the registered any_pressed summary.
module braille_key_debounce
    import braille_key_debounce_pkg::*;
#(
    parameter int NUM_KEYS  = DEFAULT_NUM_KEYS,
    parameter int STABLE_MS = DEFAULT_STABLE_MS,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1ms,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_pressed
);

    logic [1:0] rst_sync_q;
    logic       rst_int_s;
    logic       any_pressed_q;

    // Reset asserts immediately, releases two clocks after rst drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int_s = rst_sync_q[1];

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        braille_key_debounce_ch #(
            .STABLE_MS (STABLE_MS),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst_int_s),
            .tick_1ms    (tick_1ms),
            .key_raw     (key_raw[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g])
        );
    end

    // Registered OR of all debounced levels, one clock behind key_level
    always_ff @(posedge clk or posedge rst_int_s) begin
        if (rst_int_s) begin
            any_pressed_q <= 1'b0;
        end else begin
            any_pressed_q <= |key_level;
        end
    end

    assign any_pressed = any_pressed_q;

endmodule
